camera_frame_line_counter: RTL and testbench
============================================

// Module: camera_frame_line_counter
// PURPOSE
//  Measures the number of active lines in each camera frame from FVAL/LVAL timing.
//  Holds the count of the last complete frame on a stable 12-bit status word.
//  Sits directly upstream of the 12-bit Avalon input PIO, driving its in_port so the HPS can read frame height.
//  Partial frames are never reported: after reset, enable, or abort, the first frame is skipped.
// PARAMETERS
//  WIDTH     12   width of line counter and line_count output; saturation limit = 2**WIDTH-1
// PORTS
//  clk         in   1      system clock; all inputs synchronous to it
//  reset_n     in   1      asynchronous active-low reset
//  enable      in   1      1 = measure; 0 = abort and idle (from start-signal PIO)
//  fval        in   1      camera frame valid, high for whole frame
//  lval        in   1      camera line valid, high for each active line
//  line_count  out  WIDTH  line count of last completed frame (to PIO in_port)
//  sat         out  1      1 = last completed frame hit saturation limit
//  frame_done  out  1      1-cycle pulse when line_count/sat update
//  busy        out  1      1 while inside a frame being counted (state ACTIVE)
// BEHAVIOUR
//  - Reset: line_count=0, sat=0, frame_done=0, busy=0, cnt=0, fval_d=0, lval_d=0, state=SYNC.
//  - fval_d/lval_d: fval/lval registered every cycle, including when enable=0.
//  - Edges (per cycle):
//    - f_rise = fval & ~fval_d
//    - f_fall = ~fval & fval_d
//    - l_rise = lval & ~lval_d & fval
//  - States:
//    - SYNC:   wait for fval==0 -> IDLE.
//              A frame in progress at reset/enable is discarded.
//    - IDLE:   f_rise -> ACTIVE; cnt <= l_rise ? 1 : 0.
//    - ACTIVE: l_rise -> cnt <= cnt+1, saturating at 2**WIDTH-1.
//              f_fall -> IDLE; line_count <= cnt; sat <= (cnt == 2**WIDTH-1); frame_done <= 1.
//  - enable==0, any state: next state SYNC; cnt <= 0; busy <= 0.
//    - line_count and sat hold their last values; frame_done <= 0.
//    - enable==0 overrides f_fall on the same cycle: no update, no pulse.
//  - Latency: fval sampled low on edge N (state ACTIVE, f_fall) -> line_count, sat and frame_done valid after edge N.
//    frame_done high for exactly one cycle.
//  - line_count changes only together with a frame_done pulse.
//    It is stable between pulses, so the PIO may sample it on any cycle.
//  - lval rising on the same cycle fval falls: not counted (l_rise requires fval=1).
//  - lval already high when fval rises: not counted (no lval edge); a line needs an lval rising edge inside the frame.
//  - Zero-line frame (fval pulse, no lval): line_count <= 0, sat <= 0, frame_done pulses.
//  - busy registered: busy=1 iff state==ACTIVE (next-state registered with state).
//  - No other states; unreachable encodings recover to SYNC.
// TESTING
//  - Reset, enable=1, frame of fval 100 cycles with 5 lval pulses (10 high/5 low) -> after fval falls: line_count=5, sat=0, one frame_done pulse.
//  - Assert enable while fval=1 mid-frame with 3 lines left -> that frame ignored, no frame_done; next 7-line frame -> line_count=7.
//  - WIDTH=4, frame with 20 lines -> line_count=15, sat=1; next 2-line frame -> line_count=2, sat=0.
//  - Drop enable after 4 lines of a frame -> busy=0 next cycle, line_count holds previous value, no pulse.
//    Re-enable between frames -> next 6-line frame reports 6.
//  - Corner case: lval high before fval rises and lval rising on the fval-falling cycle -> neither counted.
//    3 interior lines -> line_count=3.
//  - Async reset asserted mid-frame -> all outputs 0 immediately; after release, the in-progress frame is skipped.

Source files
------------

// File: rtl/camera_frame_line_counter.sv
// Purpose : counts active lines (lval rising edges) inside each camera frame (fval
//           high) and publishes the count of the last complete frame on a stable word.
// Latency : frame end seen on edge N -> line_count/sat/frame_done valid after edge N.
// Backpressure: none; the word is held between frame_done pulses, so a reader may
//           sample it on any cycle.
//
// Ports
//   clk         system clock; all inputs are synchronous to it
//   reset_n     asynchronous active-low reset
//   enable      1 = measure, 0 = abort the current frame and idle
//   fval        camera frame valid, high for the whole frame
//   lval        camera line valid, high for each active line
//   line_count  line count of the last completed frame
//   sat         last completed frame reached the saturation limit 2**WIDTH-1
//   frame_done  one-cycle pulse coincident with each line_count/sat update
//   busy        high while a frame is being counted (state ACTIVE)

module camera_frame_line_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fval,
  input  logic             lval,
  output logic [WIDTH-1:0] line_count,
  output logic             sat,
  output logic             frame_done,
  output logic             busy
);

  // State encoding kept as plain constants for compatibility with older tools.
  localparam logic [1:0] SYNC   = 2'd0;
  localparam logic [1:0] IDLE   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             fval_d;
  logic             lval_d;
  logic             f_rise;
  logic             f_fall;
  logic             l_rise;
  logic             publish;

  // Edge detection against last cycle's inputs. A line only counts when its
  // lval edge lands while fval is high, so an lval edge on the very cycle fval
  // drops is ignored, and an lval that is already high when fval rises never
  // produces an edge at all.
  assign f_rise = fval & ~fval_d;
  assign f_fall = ~fval & fval_d;
  assign l_rise = lval & ~lval_d & fval;

  always_comb begin
    state_nxt = SYNC;
    cnt_nxt   = cnt;
    publish   = 1'b0;

    if (!enable) begin
      // Abort wins over everything, including a frame end on the same cycle.
      state_nxt = SYNC;
      cnt_nxt   = '0;
    end else begin
      case (state)
        SYNC: begin
          // A frame already under way at reset/enable is partial; wait it out.
          state_nxt = fval ? SYNC : IDLE;
        end
        IDLE: begin
          if (f_rise) begin
            state_nxt = ACTIVE;
            cnt_nxt   = l_rise ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
          end else begin
            state_nxt = IDLE;
          end
        end
        ACTIVE: begin
          if (f_fall) begin
            state_nxt = IDLE;
            publish   = 1'b1;
          end else begin
            state_nxt = ACTIVE;
            if (l_rise && (cnt != CNT_MAX)) begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = SYNC;
        end
      endcase
    end
  end

  // Input history is kept every cycle, even while disabled, so edges are
  // correct on the first enabled cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fval_d <= 1'b0;
      lval_d <= 1'b0;
    end else begin
      fval_d <= fval;
      lval_d <= lval;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SYNC;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Registered from next-state so busy tracks state exactly.
      busy  <= (state_nxt == ACTIVE);
    end
  end

  // Result word only moves together with the frame_done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_count <= '0;
      sat        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        line_count <= cnt;
        sat        <= (cnt == CNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_line_counter.sv
// Purpose : directed checks of camera_frame_line_counter at WIDTH=12 and WIDTH=4.
// Latency : inputs driven on negedge, outputs checked on following negedges.
// Backpressure: n/a.

module tb_camera_frame_line_counter;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        fval;
  logic        lval;
  logic [11:0] lc12;
  logic        sat12, fd12, busy12;
  logic [3:0]  lc4;
  logic        sat4, fd4, busy4;

  int n_cmp = 0;
  int n_bad = 0;
  int d12 = 0;
  int d4 = 0;

  camera_frame_line_counter #(.WIDTH(12)) dut12 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fval(fval), .lval(lval),
    .line_count(lc12), .sat(sat12), .frame_done(fd12), .busy(busy12)
  );

  camera_frame_line_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fval(fval), .lval(lval),
    .line_count(lc4), .sat(sat4), .frame_done(fd4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample the pre-edge value, so reads at negedges are stable.
  always @(posedge clk) begin
    if (fd12) d12 <= d12 + 1;
    if (fd4)  d4  <= d4 + 1;
  end

  task automatic hold(input logic fv, input logic lv, input int n);
    fval = fv;
    lval = lv;
    repeat (n) @(negedge clk);
  endtask

  // fval high for 2 + nl*(hi+lo) + tail cycles, then falls; returns on the
  // negedge where frame_done should be visible.
  task automatic frame(input int nl, input int hi, input int lo, input int tail);
    hold(1'b1, 1'b0, 2);
    for (int i = 0; i < nl; i++) begin
      hold(1'b1, 1'b1, hi);
      hold(1'b1, 1'b0, lo);
    end
    hold(1'b1, 1'b0, tail);
    hold(1'b0, 1'b0, 1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; fval = 1'b0; lval = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (lc12 !== 12'd0) begin n_bad++; $display("FAIL reset_lc got %0d want 0", lc12); end
    n_cmp++; if ({sat12, fd12, busy12} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {sat12, fd12, busy12}); end
    n_cmp++; if ({lc4, sat4, fd4, busy4} !== 7'd0) begin n_bad++; $display("FAIL reset_w4 got %b want 0", {lc4, sat4, fd4, busy4}); end
    reset_n = 1'b1;
    enable  = 1'b1;
    hold(1'b0, 1'b0, 3);
  endtask

  task automatic test_basic();
    int b;
    b = d12;
    frame(5, 10, 5, 23);
    n_cmp++; if (fd12 !== 1'b1) begin n_bad++; $display("FAIL basic_pulse got %b want 1", fd12); end
    n_cmp++; if (lc12 !== 12'd5) begin n_bad++; $display("FAIL basic_lc got %0d want 5", lc12); end
    n_cmp++; if (sat12 !== 1'b0) begin n_bad++; $display("FAIL basic_sat got %b want 0", sat12); end
    n_cmp++; if (busy12 !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %b want 0", busy12); end
    hold(1'b0, 1'b0, 2);
    n_cmp++; if (fd12 !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_end got %b want 0", fd12); end
    n_cmp++; if (d12 - b !== 1) begin n_bad++; $display("FAIL basic_npulse got %0d want 1", d12 - b); end
  endtask

  task automatic test_mid_enable();
    int b;
    b = d12;
    enable = 1'b0;
    hold(1'b1, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin hold(1'b1, 1'b1, 4); hold(1'b1, 1'b0, 3); end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin hold(1'b1, 1'b1, 4); hold(1'b1, 1'b0, 3); end
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 1);
    n_cmp++; if (fd12 !== 1'b0) begin n_bad++; $display("FAIL midenable_nopulse got %b want 0", fd12); end
    n_cmp++; if (lc12 !== 12'd5) begin n_bad++; $display("FAIL midenable_hold got %0d want 5", lc12); end
    hold(1'b0, 1'b0, 3);
    frame(7, 4, 3, 3);
    n_cmp++; if (lc12 !== 12'd7) begin n_bad++; $display("FAIL midenable_lc got %0d want 7", lc12); end
    hold(1'b0, 1'b0, 2);
    n_cmp++; if (d12 - b !== 1) begin n_bad++; $display("FAIL midenable_npulse got %0d want 1", d12 - b); end
  endtask

  task automatic test_saturation();
    frame(20, 2, 1, 3);
    n_cmp++; if (lc4 !== 4'd15) begin n_bad++; $display("FAIL sat_lc4 got %0d want 15", lc4); end
    n_cmp++; if (sat4 !== 1'b1) begin n_bad++; $display("FAIL sat_flag4 got %b want 1", sat4); end
    n_cmp++; if (lc12 !== 12'd20) begin n_bad++; $display("FAIL sat_lc12 got %0d want 20", lc12); end
    n_cmp++; if (sat12 !== 1'b0) begin n_bad++; $display("FAIL sat_flag12 got %b want 0", sat12); end
    hold(1'b0, 1'b0, 2);
    frame(2, 2, 1, 3);
    n_cmp++; if (lc4 !== 4'd2) begin n_bad++; $display("FAIL sat_after_lc4 got %0d want 2", lc4); end
    n_cmp++; if (sat4 !== 1'b0) begin n_bad++; $display("FAIL sat_after_flag4 got %b want 0", sat4); end
    hold(1'b0, 1'b0, 2);
  endtask

  task automatic test_disable();
    int b;
    b = d12;
    hold(1'b1, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin hold(1'b1, 1'b1, 4); hold(1'b1, 1'b0, 3); end
    n_cmp++; if (busy12 !== 1'b1) begin n_bad++; $display("FAIL dis_busy_before got %b want 1", busy12); end
    enable = 1'b0;
    hold(1'b1, 1'b0, 1);
    n_cmp++; if (busy12 !== 1'b0) begin n_bad++; $display("FAIL dis_busy_after got %b want 0", busy12); end
    n_cmp++; if (lc12 !== 12'd2) begin n_bad++; $display("FAIL dis_lc_hold got %0d want 2", lc12); end
    for (int i = 0; i < 2; i++) begin hold(1'b1, 1'b1, 4); hold(1'b1, 1'b0, 3); end
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 1);
    n_cmp++; if (fd12 !== 1'b0) begin n_bad++; $display("FAIL dis_nopulse got %b want 0", fd12); end
    hold(1'b0, 1'b0, 2);
    n_cmp++; if (d12 - b !== 0) begin n_bad++; $display("FAIL dis_npulse got %0d want 0", d12 - b); end
    enable = 1'b1;
    hold(1'b0, 1'b0, 2);
    frame(6, 4, 3, 3);
    n_cmp++; if (lc12 !== 12'd6) begin n_bad++; $display("FAIL dis_reenable_lc got %0d want 6", lc12); end
    hold(1'b0, 1'b0, 2);
  endtask

  task automatic test_corner();
    hold(1'b0, 1'b1, 3);
    hold(1'b1, 1'b1, 3);
    hold(1'b1, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin hold(1'b1, 1'b1, 2); hold(1'b1, 1'b0, 2); end
    hold(1'b0, 1'b1, 1);
    n_cmp++; if (fd12 !== 1'b1) begin n_bad++; $display("FAIL corner_pulse got %b want 1", fd12); end
    n_cmp++; if (lc12 !== 12'd3) begin n_bad++; $display("FAIL corner_lc got %0d want 3", lc12); end
    hold(1'b0, 1'b0, 2);
  endtask

  task automatic test_async_reset();
    int b;
    hold(1'b1, 1'b0, 2);
    for (int i = 0; i < 2; i++) begin hold(1'b1, 1'b1, 2); hold(1'b1, 1'b0, 2); end
    n_cmp++; if (busy12 !== 1'b1) begin n_bad++; $display("FAIL areset_busy_before got %b want 1", busy12); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({lc12, sat12, fd12, busy12} !== 15'd0) begin n_bad++; $display("FAIL areset_out12 got %h want 0", {lc12, sat12, fd12, busy12}); end
    n_cmp++; if ({lc4, sat4, fd4, busy4} !== 7'd0) begin n_bad++; $display("FAIL areset_out4 got %h want 0", {lc4, sat4, fd4, busy4}); end
    @(negedge clk);
    reset_n = 1'b1;
    b = d12;
    for (int i = 0; i < 2; i++) begin hold(1'b1, 1'b1, 2); hold(1'b1, 1'b0, 2); end
    hold(1'b0, 1'b0, 1);
    n_cmp++; if (fd12 !== 1'b0) begin n_bad++; $display("FAIL areset_skip_pulse got %b want 0", fd12); end
    n_cmp++; if (lc12 !== 12'd0) begin n_bad++; $display("FAIL areset_skip_lc got %0d want 0", lc12); end
    hold(1'b0, 1'b0, 2);
    frame(4, 2, 2, 2);
    n_cmp++; if (lc12 !== 12'd4) begin n_bad++; $display("FAIL areset_next_lc got %0d want 4", lc12); end
    n_cmp++; if (lc4 !== 4'd4) begin n_bad++; $display("FAIL areset_next_lc4 got %0d want 4", lc4); end
    hold(1'b0, 1'b0, 2);
    n_cmp++; if (d12 - b !== 1) begin n_bad++; $display("FAIL areset_npulse got %0d want 1", d12 - b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_enable();
    test_saturation();
    test_disable();
    test_corner();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
